fme_refine_ctrl: RTL and testbench

- Parametrised fractional motion-estimation sequencer. It refines an integer MV to half-pel and, optionally, quarter-pel precision.
- Per stage, it issues one request to the downstream interpolation + SATD engine, then consumes 9 candidate costs (a 3x3 grid around the current centre) and selects the minimum.
- Successor to the fixed single-shot FME controller. Adds:
  - a start/busy/done handshake
  - a per-request half-only or half+quarter mode
  - parametrised widths
  - cost-stream ordering checks and a watchdog

---
 rtl/fme_pkg.sv | 41 ++++
 rtl/fme_argmin.sv | 49 ++++
 rtl/fme_refine_ctrl.sv | 157 +++++++++++++++
 tb/tb_fme_refine_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fme_pkg.sv
// ---------------------------------------------------------------------------
// fme_pkg : shared constants, state encoding and candidate geometry. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fme_pkg;

    localparam int NCAND      = 9;
    localparam int CENTRE_IDX = 4;
    localparam int STEP_HALF  = 2;
    localparam int STEP_QUAT  = 1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_HREQ  = 3'd1;
    localparam state_t S_HCOST = 3'd2;
    localparam state_t S_QREQ  = 3'd3;
    localparam state_t S_QCOST = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } offset_t;

    // Raster order over the 3x3 grid: idx = 3*(dy+1) + (dx+1).
    function automatic offset_t cand_offset(input logic [3:0] idx);
        offset_t    o;
        logic [3:0] col;
        logic [3:0] row;
        col  = idx % 4'd3;
        row  = idx / 4'd3;
        o.dx = (col == 4'd0) ? -2'sd1 : ((col == 4'd1) ? 2'sd0 : 2'sd1);
        o.dy = (row == 4'd0) ? -2'sd1 : ((row == 4'd1) ? 2'sd0 : 2'sd1);
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fme_argmin.sv
// ---------------------------------------------------------------------------
// fme_argmin : streaming minimum tracker with centre-wins-tie rule. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fme_argmin
    import fme_pkg::*;
#(
    parameter int COST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [3:0]        idx,
    input  logic [COST_W-1:0] cost,
    output logic [3:0]        best_idx,
    output logic [COST_W-1:0] best_cost
);

    logic              r_have;
    logic [3:0]        r_idx;
    logic [COST_W-1:0] r_cost;
    logic              w_take;

    assign w_take = valid && (!r_have || (cost < r_cost) ||
                              ((cost == r_cost) && (idx == 4'(CENTRE_IDX))));

    // Outputs already fold in this cycle's candidate so the caller can act on idx 8.
    assign best_idx  = w_take ? idx  : r_idx;
    assign best_cost = w_take ? cost : r_cost;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_have <= 1'b0;
            r_idx  <= '0;
            r_cost <= '0;
        end else if (clear) begin
            r_have <= 1'b0;
        end else if (w_take) begin
            r_have <= 1'b1;
            r_idx  <= idx;
            r_cost <= cost;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fme_refine_ctrl.sv
// ---------------------------------------------------------------------------
// fme_refine_ctrl : half/quarter-pel fractional ME search sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fme_refine_ctrl
    import fme_pkg::*;
#(
    parameter int COST_W      = 16,
    parameter int MV_W        = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              qpel_en,
    input  logic [MV_W-1:0]   int_mv_x,
    input  logic [MV_W-1:0]   int_mv_y,
    output logic              busy,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [1:0]        req_step,
    output logic [MV_W+1:0]   req_ctr_x,
    output logic [MV_W+1:0]   req_ctr_y,
    input  logic              cost_valid,
    input  logic [3:0]        cost_idx,
    input  logic [COST_W-1:0] cost,
    output logic              done,
    output logic [MV_W+1:0]   best_mv_x,
    output logic [MV_W+1:0]   best_mv_y,
    output logic [COST_W-1:0] best_cost,
    output logic              err
);

    localparam int CW = MV_W + 2;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t            r_state;
    logic              r_qpel;
    logic [CW-1:0]     r_base_x, r_base_y;
    logic [CW-1:0]     r_ctr_x, r_ctr_y;
    logic [3:0]        r_exp_idx;
    logic [TW-1:0]     r_tmo;
    logic [CW-1:0]     r_best_x, r_best_y;
    logic [COST_W-1:0] r_best_cost;
    logic              r_err;

    logic              w_in_cost, w_accept, w_idx_err, w_tmo_err, w_last;
    logic [3:0]        w_min_idx;
    logic [COST_W-1:0] w_min_cost;
    offset_t           w_off;
    logic [CW-1:0]     w_off_x, w_off_y, w_cand_x, w_cand_y;

    assign w_in_cost = (r_state == S_HCOST) || (r_state == S_QCOST);
    assign w_accept  = w_in_cost && cost_valid;
    assign w_idx_err = w_accept && (cost_idx != r_exp_idx);
    assign w_tmo_err = w_in_cost && !cost_valid && (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_last    = w_accept && !w_idx_err && (r_exp_idx == 4'(NCAND - 1));

    fme_argmin #(.COST_W(COST_W)) u_argmin (
        .clk       (clk),
        .rst       (rst),
        .clear     (req_valid && req_ready),
        .valid     (w_accept && !w_idx_err),
        .idx       (cost_idx),
        .cost      (cost),
        .best_idx  (w_min_idx),
        .best_cost (w_min_cost)
    );

    // Winning candidate MV; half-pel offsets are doubled into qpel units.
    assign w_off    = cand_offset(w_min_idx);
    assign w_off_x  = {{(CW-2){w_off.dx[1]}}, w_off.dx};
    assign w_off_y  = {{(CW-2){w_off.dy[1]}}, w_off.dy};
    assign w_cand_x = r_ctr_x + ((r_state == S_HCOST) ? (w_off_x << 1) : w_off_x);
    assign w_cand_y = r_ctr_y + ((r_state == S_HCOST) ? (w_off_y << 1) : w_off_y);

    assign busy      = (r_state != S_IDLE);
    assign req_valid = (r_state == S_HREQ) || (r_state == S_QREQ);
    assign req_step  = (r_state == S_QREQ) ? 2'(STEP_QUAT) : 2'(STEP_HALF);
    assign req_ctr_x = r_ctr_x;
    assign req_ctr_y = r_ctr_y;
    assign done      = (r_state == S_DONE);
    assign best_mv_x = r_best_x;
    assign best_mv_y = r_best_y;
    assign best_cost = r_best_cost;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_qpel      <= 1'b0;
            r_base_x    <= '0;
            r_base_y    <= '0;
            r_ctr_x     <= '0;
            r_ctr_y     <= '0;
            r_exp_idx   <= '0;
            r_tmo       <= '0;
            r_best_x    <= '0;
            r_best_y    <= '0;
            r_best_cost <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_qpel   <= qpel_en;
                        r_base_x <= {int_mv_x, 2'b00};
                        r_base_y <= {int_mv_y, 2'b00};
                        r_ctr_x  <= {int_mv_x, 2'b00};
                        r_ctr_y  <= {int_mv_y, 2'b00};
                        r_err    <= 1'b0;
                        r_state  <= S_HREQ;
                    end
                end
                S_HREQ, S_QREQ: begin
                    if (req_ready) begin
                        r_exp_idx <= '0;
                        r_tmo     <= '0;
                        r_state   <= (r_state == S_HREQ) ? S_HCOST : S_QCOST;
                    end
                end
                S_HCOST, S_QCOST: begin
                    if (w_idx_err || w_tmo_err) begin
                        r_err       <= 1'b1;
                        r_best_x    <= r_base_x;
                        r_best_y    <= r_base_y;
                        r_best_cost <= '1;
                        r_state     <= S_DONE;
                    end else if (w_accept) begin
                        r_exp_idx <= r_exp_idx + 4'd1;
                        r_tmo     <= '0;
                        if (w_last) begin
                            r_ctr_x <= w_cand_x;
                            r_ctr_y <= w_cand_y;
                            if ((r_state == S_HCOST) && r_qpel) begin
                                r_state <= S_QREQ;
                            end else begin
                                r_best_x    <= w_cand_x;
                                r_best_y    <= w_cand_y;
                                r_best_cost <= w_min_cost;
                                r_state     <= S_DONE;
                            end
                        end
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fme_refine_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fme_refine_ctrl : directed + randomized checks against a search model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fme_refine_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        qpel_en = 1'b0;
    logic [7:0]  int_mv_x = '0;
    logic [7:0]  int_mv_y = '0;
    logic        req_ready = 1'b0;
    logic        cost_valid = 1'b0;
    logic [3:0]  cost_idx = '0;
    logic [15:0] cost = '0;
    logic        busy, req_valid, done, err;
    logic [1:0]  req_step;
    logic [9:0]  req_ctr_x, req_ctr_y, best_mv_x, best_mv_y;
    logic [15:0] best_cost;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hc[9];
    int qc[9];

    fme_refine_ctrl #(.COST_W(16), .MV_W(8), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .start(start), .qpel_en(qpel_en),
        .int_mv_x(int_mv_x), .int_mv_y(int_mv_y), .busy(busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_step(req_step),
        .req_ctr_x(req_ctr_x), .req_ctr_y(req_ctr_y), .cost_valid(cost_valid),
        .cost_idx(cost_idx), .cost(cost), .done(done), .best_mv_x(best_mv_x),
        .best_mv_y(best_mv_y), .best_cost(best_cost), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] m10(input int v);
        return v[9:0];
    endfunction

    // Lowest cost wins; the centre takes any tie for the minimum, else the earliest index.
    function automatic int pick(input bit q);
        int c[9];
        int m;
        for (int i = 0; i < 9; i++) c[i] = q ? qc[i] : hc[i];
        m = c[0];
        for (int i = 1; i < 9; i++) if (c[i] < m) m = c[i];
        if (c[4] == m) return 4;
        for (int i = 0; i < 9; i++) if (c[i] == m) return i;
        return 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_req(input int exp_cyc, input string tag);
        int n = 0;
        while (req_valid !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_req_cycle"}, cyc, exp_cyc);
    endtask

    task automatic req_phase(input int bp, input logic [1:0] st, input int cx, input int cy,
                             input string tag);
        for (int i = 0; i <= bp; i++) begin
            req_ready = (i == bp);
            chk({tag, "_req_valid"}, req_valid, 1);
            chk({tag, "_req_step"}, req_step, st);
            chk({tag, "_req_ctr_x"}, req_ctr_x, m10(cx));
            chk({tag, "_req_ctr_y"}, req_ctr_y, m10(cy));
            tick;
        end
        req_ready = 1'b0;
    endtask

    task automatic stream(input bit q, input int gmax, input int err_at, input bit poke,
                          output int gsum);
        int g;
        gsum = 0;
        for (int k = 0; k < 9; k++) begin
            g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
            gsum += g;
            cost_valid = 1'b0;
            repeat (g) tick;
            cost_valid = 1'b1;
            cost_idx   = (k == err_at) ? 4'(k + 1) : 4'(k);
            cost       = q ? 16'(qc[k]) : 16'(hc[k]);
            if (poke && k == 0) begin
                start    = 1'b1;
                qpel_en  = ~qpel_en;
                int_mv_x = 8'($urandom);
                int_mv_y = 8'($urandom);
            end
            tick;
            start = 1'b0;
            if (k == err_at) break;
        end
        cost_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input int ex, input int ey, input int ec,
                             input bit ee, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick;
            n++;
        end
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 1);
        chk({tag, "_best_x"}, best_mv_x, m10(ex));
        chk({tag, "_best_y"}, best_mv_y, m10(ey));
        chk({tag, "_best_cost"}, best_cost, ec);
        chk({tag, "_err"}, err, ee);
        tick;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold_x"}, best_mv_x, m10(ex));
    endtask

    task automatic run(input bit qp, input int mx, input int my, input int bph, input int bpq,
                       input int gmax, input int err_at, input bit tmo, input bit poke,
                       input string tag);
        int cx, cy, b, g, g2, t, exp_done;
        cx = mx * 4;
        cy = my * 4;
        cyc        = 0;
        start      = 1'b1;
        qpel_en    = qp;
        int_mv_x   = 8'(mx);
        int_mv_y   = 8'(my);
        tick;
        start      = 1'b0;
        int_mv_x   = 8'($urandom);
        int_mv_y   = 8'($urandom);
        qpel_en    = 1'($urandom);
        chk({tag, "_busy"}, busy, 1);
        wait_req(1, {tag, "_h"});
        req_phase(bph, 2'd2, cx, cy, {tag, "_h"});
        t = 2 + bph;
        if (tmo) begin
            wait_done(t + 8, mx * 4, my * 4, 16'hFFFF, 1'b1, tag);
        end else if (err_at >= 0) begin
            stream(1'b0, gmax, err_at, poke, g);
            wait_done(t + err_at + g + 1, mx * 4, my * 4, 16'hFFFF, 1'b1, tag);
        end else begin
            stream(1'b0, gmax, -1, poke, g);
            b  = pick(1'b0);
            cx = cx + 2 * (b % 3 - 1);
            cy = cy + 2 * (b / 3 - 1);
            exp_done = 11 + bph + g;
            if (qp) begin
                wait_req(exp_done, {tag, "_q"});
                req_phase(bpq, 2'd1, cx, cy, {tag, "_q"});
                stream(1'b1, gmax, -1, 1'b0, g2);
                b  = pick(1'b1);
                cx = cx + (b % 3 - 1);
                cy = cy + (b / 3 - 1);
                exp_done = exp_done + bpq + 10 + g2;
                wait_done(exp_done, cx, cy, qc[b], 1'b0, tag);
            end else begin
                wait_done(exp_done, cx, cy, hc[b], 1'b0, tag);
            end
        end
    endtask

    initial begin
        int g, d;
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_step", req_step, 2);
        chk("rst_ctr_x", req_ctr_x, 0);
        chk("rst_best", {best_mv_x, best_mv_y, best_cost}, 0);
        rst = 1'b1;
        tick;

        hc = '{50, 40, 40, 60, 40, 70, 80, 90, 99};
        run(1'b0, 3, -2, 0, 0, 0, -1, 1'b0, 1'b0, "half");

        hc = '{30, 25, 20, 28, 15, 10, 40, 35, 50};
        qc = '{12, 11, 9, 7, 8, 20, 30, 14, 9};
        run(1'b1, 0, 0, 0, 0, 0, -1, 1'b0, 1'b0, "quarter");

        hc = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        run(1'b0, -5, 7, 0, 0, 0, -1, 1'b0, 1'b0, "tie");

        hc = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        qc = '{3, 3, 3, 3, 4, 3, 3, 3, 3};
        run(1'b1, 10, -20, 5, 5, 0, -1, 1'b0, 1'b0, "bp");

        run(1'b1, 4, -3, 0, 0, 0, 2, 1'b0, 1'b0, "idx_err");
        run(1'b1, -7, 2, 1, 0, 0, -1, 1'b1, 1'b0, "timeout");

        // Abort in the quarter stage, then confirm silence and a clean restart.
        hc = '{5, 5, 5, 5, 1, 5, 5, 5, 5};
        cyc = 0;
        start = 1'b1; qpel_en = 1'b1; int_mv_x = 8'd2; int_mv_y = 8'd1;
        tick;
        start = 1'b0;
        wait_req(1, "abort_h");
        req_phase(0, 2'd2, 8, 4, "abort_h");
        stream(1'b0, 0, -1, 1'b0, g);
        wait_req(11, "abort_q");
        req_phase(0, 2'd1, 8, 4, "abort_q");
        for (int k = 0; k < 4; k++) begin
            cost_valid = 1'b1; cost_idx = 4'(k); cost = 16'd3;
            tick;
        end
        cost_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_req_valid", req_valid, 0);
        chk("abort_step", req_step, 2);
        chk("abort_ctr", {req_ctr_x, req_ctr_y}, 0);
        tick;
        tick;
        rst = 1'b1;
        d = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (done === 1'b1) d++;
        end
        chk("abort_no_done", d, 0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 9; i++) begin
                hc[i] = int'($urandom_range(15, 0));
                qc[i] = int'($urandom_range(15, 0));
            end
            run(1'($urandom), int'($urandom_range(255, 0)) - 128, int'($urandom_range(255, 0)) - 128,
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 3, -1, 1'b0,
                (r % 3) == 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
